// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the iterative FFT frame controller.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {ST_LOAD, ST_ISSUE, ST_DRAIN, ST_UNLOAD} fft_ctrl_state_t;

  localparam int MAX_L = 16;

  // Stage counter width: must hold 0..L-1.
  function automatic int stage_w(input int l);
    return (l > 2) ? $clog2(l) : 1;
  endfunction

  function automatic int tw_w(input int l);
    return (l > 1) ? l - 1 : 1;
  endfunction

  function automatic logic [MAX_L-1:0] bitrev(input logic [MAX_L-1:0] idx, input int l);
    logic [MAX_L-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_L; i++)
      if (i < l) r[i] = idx[l-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT butterfly address and twiddle generation for stage s, butterfly k.
module fft_addr_gen
  import fft_ctrl_pkg::*;
#(
  parameter int L  = 2,
  parameter int SW = 1
)(
  input  logic [SW-1:0] i_stage,
  input  logic [L-2:0]  i_k,
  output logic [L-1:0]  o_a,
  output logic [L-1:0]  o_b,
  output logic [L-2:0]  o_tw
);

  localparam logic [SW-1:0] LM1 = SW'(L-1);

  logic [L-2:0] w_mask;
  logic [L-1:0] w_k;

  assign w_mask = ((L-1)'(1) << i_stage) - (L-1)'(1);
  assign w_k    = {1'b0, i_k};
  // k < 2^(L-1), so the extra left shift never overflows L bits.
  assign o_a    = (((w_k >> i_stage) << i_stage) << 1) | {1'b0, i_k & w_mask};
  assign o_b    = o_a + (L'(1) << i_stage);
  assign o_tw   = (i_k & w_mask) << (LM1 - i_stage);

endmodule

// File: rtl/fft_iterative_scheduler.sv
// Frame controller for an iterative radix-2 DIT FFT sharing one external pipelined butterfly.
module fft_iterative_scheduler
  import fft_ctrl_pkg::*;
#(
  parameter int SAMPLES    = 4,
  parameter int WIDTH      = 32,
  parameter int BF_LATENCY = 1
)(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_data,
  output logic                               out_last,
  output logic                               bf_issue,
  output logic [WIDTH-1:0]                   bf_a,
  output logic [WIDTH-1:0]                   bf_b,
  output logic [tw_w($clog2(SAMPLES))-1:0]   bf_tw_idx,
  input  logic [WIDTH-1:0]                   bf_y0,
  input  logic [WIDTH-1:0]                   bf_y1,
  output logic                               busy,
  output logic                               frame_done
);

  localparam int L  = $clog2(SAMPLES);
  localparam int SW = stage_w(L);
  localparam int DW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
  localparam logic [L-1:0]  CNT_MAX = L'(SAMPLES-1);
  localparam logic [L-2:0]  K_MAX   = (L-1)'(SAMPLES/2-1);
  localparam logic [SW-1:0] S_MAX   = SW'(L-1);
  localparam logic [DW-1:0] D_MAX   = DW'(BF_LATENCY-1);

  fft_ctrl_state_t r_state;
  logic [L-1:0]    r_cnt;
  logic [L-2:0]    r_k;
  logic [SW-1:0]   r_stage;
  logic [DW-1:0]   r_drain;
  logic [WIDTH-1:0] r_buf [SAMPLES];

  logic [BF_LATENCY-1:0]         r_vld_pipe;
  logic [BF_LATENCY-1:0][L-1:0]  r_a_pipe;
  logic [BF_LATENCY-1:0][L-1:0]  r_b_pipe;

  logic [L-1:0] w_a, w_b, w_wr_idx;
  logic [L-2:0] w_tw;
  logic         w_in_hs, w_wb;

  fft_addr_gen #(.L(L), .SW(SW)) u_addr (
    .i_stage (r_stage),
    .i_k     (r_k),
    .o_a     (w_a),
    .o_b     (w_b),
    .o_tw    (w_tw)
  );

  assign in_ready   = (r_state == ST_LOAD);
  assign busy       = !in_ready;
  assign bf_issue   = (r_state == ST_ISSUE);
  assign out_valid  = (r_state == ST_UNLOAD);
  assign bf_a       = bf_issue ? r_buf[w_a] : '0;
  assign bf_b       = bf_issue ? r_buf[w_b] : '0;
  assign bf_tw_idx  = bf_issue ? w_tw : '0;
  assign out_data   = out_valid ? r_buf[r_cnt] : '0;
  assign out_last   = out_valid && (r_cnt == CNT_MAX);
  assign frame_done = out_last && out_ready;

  assign w_in_hs  = in_valid && in_ready;
  assign w_wr_idx = L'(bitrev(MAX_L'(r_cnt), L));
  assign w_wb     = r_vld_pipe[BF_LATENCY-1];

  // Buffer contents survive reset; only the writes are suppressed on a reset edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_in_hs) r_buf[w_wr_idx] <= in_data;
      if (w_wb) begin
        r_buf[r_a_pipe[BF_LATENCY-1]] <= bf_y0;
        r_buf[r_b_pipe[BF_LATENCY-1]] <= bf_y1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_LOAD;
      r_cnt      <= '0;
      r_k        <= '0;
      r_stage    <= '0;
      r_drain    <= '0;
      r_vld_pipe <= '0;
      r_a_pipe   <= '0;
      r_b_pipe   <= '0;
    end else begin
      r_vld_pipe[0] <= bf_issue;
      r_a_pipe[0]   <= w_a;
      r_b_pipe[0]   <= w_b;
      for (int i = 1; i < BF_LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_a_pipe[i]   <= r_a_pipe[i-1];
        r_b_pipe[i]   <= r_b_pipe[i-1];
      end
      case (r_state)
        ST_LOAD: if (w_in_hs) begin
          if (r_cnt == CNT_MAX) begin
            r_cnt   <= '0;
            r_stage <= '0;
            r_k     <= '0;
            r_state <= ST_ISSUE;
          end else r_cnt <= r_cnt + L'(1);
        end
        ST_ISSUE: begin
          if (r_k == K_MAX) begin
            r_k     <= '0;
            r_drain <= '0;
            r_state <= ST_DRAIN;
          end else r_k <= r_k + (L-1)'(1);
        end
        // Drain lets the last writeback of the stage land before the next stage reads.
        ST_DRAIN: begin
          if (r_drain == D_MAX) begin
            r_drain <= '0;
            if (r_stage == S_MAX) begin
              r_cnt   <= '0;
              r_state <= ST_UNLOAD;
            end else begin
              r_stage <= r_stage + SW'(1);
              r_k     <= '0;
              r_state <= ST_ISSUE;
            end
          end else r_drain <= r_drain + DW'(1);
        end
        ST_UNLOAD: if (out_ready) begin
          if (r_cnt == CNT_MAX) begin
            r_cnt   <= '0;
            r_state <= ST_LOAD;
          end else r_cnt <= r_cnt + L'(1);
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_iterative_scheduler.sv
// Scoreboard bench: an N=4 instance with a complex butterfly and an N=8, 3-cycle-latency instance.
module tb_fft_iterative_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] cx(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  // Words are {re[15:0], im[15:0]}; negj selects W = -j, else W = 1.
  function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b, input logic negj);
    logic signed [15:0] wr, wi;
    wr = negj ? b[15:0] : b[31:16];
    wi = negj ? -b[31:16] : b[15:0];
    return {a[31:16] + wr, a[15:0] + wi, a[31:16] - wr, a[15:0] - wi};
  endfunction

  function automatic int br3(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  // With unit twiddles the iterative DIT reduces to signs (-1)^popcount(k & bitrev(n)).
  function automatic logic [31:0] ref8(input int k, input int x [8]);
    int s;
    s = 0;
    for (int n = 0; n < 8; n++)
      s += ($countones(k & br3(n)) % 2 == 1) ? -x[n] : x[n];
    return cx(s, 0);
  endfunction

  // ---------------- N=4, BF_LATENCY=1 ----------------
  logic        rst4, iv4, ir4, ov4, or4, ol4, is4, busy4, fd4;
  logic [31:0] id4, od4, a4, b4, y04, y14;
  logic [0:0]  tw4;

  fft_iterative_scheduler #(.SAMPLES(4), .WIDTH(32), .BF_LATENCY(1)) dut4 (
    .clk(clk), .reset(rst4),
    .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_last(ol4),
    .bf_issue(is4), .bf_a(a4), .bf_b(b4), .bf_tw_idx(tw4),
    .bf_y0(y04), .bf_y1(y14), .busy(busy4), .frame_done(fd4)
  );

  always @(posedge clk) {y04, y14} <= bfly(a4, b4, tw4[0]);

  // ---------------- N=8, BF_LATENCY=3 ----------------
  logic        rst8, iv8, ir8, ov8, or8, ol8, is8, busy8, fd8;
  logic [31:0] id8, od8, a8, b8, y08, y18;
  logic [1:0]  tw8;
  logic [63:0] p8 [3];

  fft_iterative_scheduler #(.SAMPLES(8), .WIDTH(32), .BF_LATENCY(3)) dut8 (
    .clk(clk), .reset(rst8),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_last(ol8),
    .bf_issue(is8), .bf_a(a8), .bf_b(b8), .bf_tw_idx(tw8),
    .bf_y0(y08), .bf_y1(y18), .busy(busy8), .frame_done(fd8)
  );

  // Unit twiddles keep N=8 results integer; the twiddle index is checked directly.
  always @(posedge clk) begin
    p8[0] <= bfly(a8, b8, 1'b0);
    p8[1] <= p8[0];
    p8[2] <= p8[1];
  end
  assign {y08, y18} = p8[2];

  logic [31:0] q4[$];
  logic [31:0] q8[$];

  // ---------------- monitors ----------------
  int oi4 = 0;
  always @(negedge clk) if (!rst4) begin
    check("n4_frame_done", fd4, ov4 && or4 && oi4 == 3);
    if (ov4) check("n4_in_ready_busy", ir4, 0);
    if (ov4 && or4) begin
      if (q4.size() == 0) check("n4_unexpected_out", 32'(q4.size()), 1);
      else begin
        check("n4_data", od4, q4.pop_front());
        check("n4_last", ol4, oi4 == 3);
        oi4 <= (oi4 == 3) ? 0 : oi4 + 1;
      end
    end
  end

  int          oi8 = 0, ni8 = 0, t_in8 = 0;
  logic        stall8 = 0, hold_l8 = 0, armed8 = 0, lat_done8 = 0;
  logic [31:0] hold_d8 = 0;
  int ea8 [4] = '{0, 2, 1, 3};
  int eb8 [4] = '{4, 6, 5, 7};
  int et1 [4] = '{0, 2, 0, 2};

  always @(negedge clk) if (!rst8) begin
    check("n8_frame_done", fd8, ov8 && or8 && oi8 == 7);
    if (busy8) check("n8_in_ready_busy", ir8, 0);
    if (ov8 && stall8) begin
      check("n8_hold_data", od8, hold_d8);
      check("n8_hold_last", ol8, hold_l8);
    end
    stall8  <= ov8 && !or8;
    hold_d8 <= od8;
    hold_l8 <= ol8;
    if (ov8 && or8) begin
      if (q8.size() == 0) check("n8_unexpected_out", 32'(q8.size()), 1);
      else begin
        check("n8_data", od8, q8.pop_front());
        check("n8_last", ol8, oi8 == 7);
        oi8 <= (oi8 == 7) ? 0 : oi8 + 1;
      end
    end
    if (is8) begin
      if (ni8 < 4) begin
        check("n8_s0_bf_a", a8, cx(ea8[ni8], 0));
        check("n8_s0_bf_b", b8, cx(eb8[ni8], 0));
        check("n8_s0_tw", tw8, 0);
      end else if (ni8 < 8) check("n8_s1_tw", tw8, et1[ni8-4]);
      else if (ni8 < 12) check("n8_s2_tw", tw8, ni8 - 8);
      ni8 <= ni8 + 1;
    end
    if (iv8 && ir8 && !armed8) begin
      t_in8  <= cyc;
      armed8 <= 1'b1;
    end
    if (ov8 && armed8 && !lat_done8) begin
      check("n8_latency", cyc - t_in8, 29);
      lat_done8 <= 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic load4(input logic [31:0] d [4]);
    for (int i = 0; i < 4; i++) begin
      iv4 = 1'b1; id4 = d[i];
      @(negedge clk); check("n4_load_ready", ir4, 1);
      @(posedge clk); #1;
    end
    iv4 = 1'b0; id4 = '0;
  endtask

  task automatic load8(input int x [8]);
    for (int i = 0; i < 8; i++) begin
      iv8 = 1'b1; id8 = cx(x[i], 0);
      @(posedge clk); #1;
    end
    iv8 = 1'b0; id8 = '0;
  endtask

  task automatic wait_idle4();
    int n;
    n = 0;
    while ((q4.size() != 0 || busy4) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("n4_frame_in_time", n < 400, 1);
  endtask

  task automatic wait_idle8(input logic rnd);
    int n;
    n = 0;
    while ((q8.size() != 0 || busy8) && n < 1000) begin
      or8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; n++;
    end
    or8 = 1'b1;
    check("n8_frame_in_time", n < 1000, 1);
  endtask

  logic [31:0] d4 [4];
  logic [31:0] e4 [4];
  int          x8 [8];

  initial begin
    int ni, n;
    rst4 = 1; rst8 = 1;
    iv4 = 0; iv8 = 0; id4 = '0; id8 = '0; or4 = 1; or8 = 1;
    repeat (3) @(posedge clk);
    #1; rst4 = 0; rst8 = 0;
    @(negedge clk);
    check("rst4_in_ready", ir4, 1);
    check("rst4_out_valid", ov4, 0);
    check("rst4_bf_issue", is4, 0);
    check("rst4_busy", busy4, 0);
    check("rst4_out_data", od4, 0);
    check("rst8_in_ready", ir8, 1);
    check("rst8_out_valid", ov8, 0);
    check("rst8_busy", busy8, 0);
    @(posedge clk); #1;

    // impulse -> flat spectrum
    d4 = '{cx(1,0), cx(0,0), cx(0,0), cx(0,0)};
    e4 = '{cx(1,0), cx(1,0), cx(1,0), cx(1,0)};
    foreach (e4[i]) q4.push_back(e4[i]);
    load4(d4);
    wait_idle4();

    // DC -> single bin
    d4 = '{cx(1,0), cx(1,0), cx(1,0), cx(1,0)};
    e4 = '{cx(4,0), cx(0,0), cx(0,0), cx(0,0)};
    foreach (e4[i]) q4.push_back(e4[i]);
    load4(d4);
    wait_idle4();

    // ramp exercises the -j twiddle
    d4 = '{cx(1,0), cx(2,0), cx(3,0), cx(4,0)};
    e4 = '{cx(10,0), cx(-2,2), cx(-2,0), cx(-2,-2)};
    foreach (e4[i]) q4.push_back(e4[i]);
    load4(d4);
    wait_idle4();

    // N=8 ramp with random backpressure, then a reversed ramp without stalls
    for (int i = 0; i < 8; i++) x8[i] = i;
    for (int k = 0; k < 8; k++) q8.push_back(ref8(k, x8));
    load8(x8);
    wait_idle8(1'b1);
    for (int i = 0; i < 8; i++) x8[i] = 7 - i;
    for (int k = 0; k < 8; k++) q8.push_back(ref8(k, x8));
    load8(x8);
    wait_idle8(1'b0);
    check("n8_issue_total", ni8, 24);

    // reset during stage-1 ISSUE drops the frame
    d4 = '{cx(1,0), cx(2,0), cx(3,0), cx(4,0)};
    load4(d4);
    ni = 0; n = 0;
    while (ni < 3 && n < 50) begin
      @(negedge clk);
      if (is4) ni++;
      n++;
    end
    check("n4_reach_stage1", ni, 3);
    @(posedge clk); #1;
    rst4 = 1;
    @(negedge clk);
    check("n4_pre_rst_issue", is4, 1);
    check("n4_pre_rst_tw", tw4, 1);
    @(posedge clk); #1;
    rst4 = 0;
    @(negedge clk);
    check("n4_post_rst_in_ready", ir4, 1);
    check("n4_post_rst_issue", is4, 0);
    check("n4_post_rst_busy", busy4, 0);
    check("n4_post_rst_out_valid", ov4, 0);
    @(posedge clk); #1;
    d4 = '{cx(1,0), cx(1,0), cx(1,0), cx(1,0)};
    e4 = '{cx(4,0), cx(0,0), cx(0,0), cx(0,0)};
    foreach (e4[i]) q4.push_back(e4[i]);
    load4(d4);
    wait_idle4();

    check("q4_drained", q4.size(), 0);
    check("q8_drained", q8.size(), 0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
